// File: rtl/audio_pkg.sv
// audio_pkg: shared types, field layout and timing constants for the note sequencer
package audio_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
  localparam int FREQ_W = 12;
  localparam int DUR_W = 16;
  localparam int FREQ_LSB = 0;
  localparam int DUR_LSB = 12;
  localparam int ENTRY_W = FREQ_W + DUR_W;
  localparam int GAP_MS = 10;
  function automatic logic [FREQ_W-1:0] entry_freq(input logic [ENTRY_W-1:0] e);
    return e[FREQ_LSB +: FREQ_W];
  endfunction
  function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] e);
    return e[DUR_LSB +: DUR_W];
  endfunction
endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: CPU write side and tone-generator side of the note sequencer
interface note_sequencer_if;
  import audio_pkg::*;
  logic wr_en;
  logic [31:0] wr_data;
  logic stop;
  logic [FREQ_W-1:0] freq_out;
  logic note_active;
  logic full;
  logic empty;
  logic overflow;
  modport master(output wr_en, wr_data, stop, input freq_out, note_active, full, empty, overflow);
  modport slave(input wr_en, wr_data, stop, output freq_out, note_active, full, empty, overflow);
endinterface

// File: rtl/note_fifo.sv
// note_fifo: synchronous FIFO with flush and same-cycle push/pop when full
module note_fifo #(
  parameter int W = 28,
  parameter int DEPTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         single
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp, used;
  assign used = wp - rp;
  assign full = used == (AW+1)'(DEPTH);
  assign empty = used == '0;
  assign single = used == (AW+1)'(1);
  assign dout = mem[rp[AW-1:0]];
  // pointers carry an extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= push ? wp + (AW+1)'(1) : wp;
      rp <= pop ? rp + (AW+1)'(1) : rp;
    end
  end
  // storage write; the caller only pushes into a full queue when it also pops
  always_ff @(posedge clock) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: queues (freq, duration) commands and plays them in order; NOTE_SEQ_GAP_EN adds a 10 ms silence after each note
module note_sequencer import audio_pkg::*; #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int FIFO_DEPTH = 8
) (
  input logic clock,
  input logic reset,
  note_sequencer_if.slave bus
);
  localparam int TC = CLK_FREQ_HZ / 1000;
  localparam int CW = $clog2(TC + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DUR_W-1:0] ms_left;
  logic [FREQ_W-1:0] freq;
  logic [ENTRY_W-1:0] head;
  logic full, empty, single, pop, push, timing, tick, last_ms, zero_dur, load_ok, overflow;
  logic unused;
  assign unused = &{1'b0, bus.wr_data[31:ENTRY_W]};
  assign push = bus.wr_en && (!full || pop) && !bus.stop;
  assign timing = state == PLAY || state == GAP;
  assign tick = timing && cnt == CW'(TC - 1);
  assign last_ms = tick && ms_left == DUR_W'(1);
  assign zero_dur = entry_dur(head) == '0;
  assign load_ok = state == LOAD && !zero_dur;
  note_fifo #(.W(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock), .reset(reset), .flush(bus.stop), .push(push), .pop(pop),
    .din(bus.wr_data[ENTRY_W-1:0]), .dout(head), .full(full), .empty(empty), .single(single)
  );
  // state register
  always_ff @(posedge clock) begin
    state <= reset ? IDLE : state_nx;
  end
  // next state; a skipped zero-length note chains straight into the next load
  always_comb begin
    state_nx = bus.stop ? IDLE :
               state == IDLE ? (empty ? IDLE : LOAD) :
               state == LOAD ? (zero_dur ? ((!single || push) ? LOAD : IDLE) : PLAY) :
               state == PLAY ? PLAY :
               (last_ms ? (empty ? IDLE : LOAD) : GAP);
    if (state == PLAY && last_ms && !bus.stop) begin
`ifdef NOTE_SEQ_GAP_EN
      state_nx = GAP;
`else
      state_nx = empty ? IDLE : LOAD;
`endif
    end
  end
  // state-decoded outputs
  always_comb begin
    pop = state == LOAD && !bus.stop;
    bus.note_active = state == PLAY;
  end
  // millisecond prescaler; restarts on every PLAY/GAP entry so no partial tick carries over
  always_ff @(posedge clock) begin
    cnt <= (reset || bus.stop || !timing || state_nx != state || tick) ? '0 : cnt + CW'(1);
  end
  // frequency and remaining-time registers; freq holds through LOAD so back-to-back notes do not glitch
  always_ff @(posedge clock) begin
    if (reset || bus.stop) begin
      freq <= '0;
      ms_left <= '0;
    end else begin
      freq <= (state_nx == IDLE || state_nx == GAP) ? '0 : load_ok ? entry_freq(head) : freq;
      ms_left <= load_ok ? entry_dur(head) :
                 (state == PLAY && last_ms) ? DUR_W'(GAP_MS) :
                 tick ? ms_left - DUR_W'(1) : ms_left;
    end
  end
  // sticky flag for writes lost to a full queue
  always_ff @(posedge clock) begin
    overflow <= reset ? 1'b0 : (overflow || (bus.wr_en && full && !pop && !bus.stop));
  end
  assign bus.freq_out = freq;
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.overflow = overflow;
endmodule
